axi4_error_responder: RTL and testbench



---
 rtl/axi4_error_responder.sv | 157 +++++++++++++++
 tb/tb_axi4_error_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_error_responder.sv
// AXI4 subordinate that terminates every request with an error response.
// Define AXI4_ERR_RESPONDER_ECHO_EN to capture and return the AW/AR echo field.
//
// state  | meaning
// W_IDLE | waiting for AW, W stalled
// W_DATA | draining W beats until w_last
// W_RESP | holding B until accepted
// R_IDLE | waiting for AR
// R_DATA | streaming error beats, last when count == captured len
module axi4_error_responder #(
    parameter int         ID_W     = 4,
    parameter int         DATA_W   = 64,
    parameter int         STRB_W   = DATA_W / 8,
    parameter int         ECHO_W   = 5,
    parameter logic [1:0] ERR_RESP = 2'b11
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              aw_valid,
    output logic              aw_ready,
    input  logic [ID_W-1:0]   aw_id,
    input  logic [31:0]       aw_addr,
    input  logic [7:0]        aw_len,
    input  logic [2:0]        aw_size,
    input  logic [1:0]        aw_burst,
    input  logic [ECHO_W-1:0] aw_echo,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [DATA_W-1:0] w_data,
    input  logic [STRB_W-1:0] w_strb,
    input  logic              w_last,
    output logic              b_valid,
    input  logic              b_ready,
    output logic [ID_W-1:0]   b_id,
    output logic [1:0]        b_resp,
    output logic [ECHO_W-1:0] b_echo,
    input  logic              ar_valid,
    output logic              ar_ready,
    input  logic [ID_W-1:0]   ar_id,
    input  logic [31:0]       ar_addr,
    input  logic [7:0]        ar_len,
    input  logic [2:0]        ar_size,
    input  logic [1:0]        ar_burst,
    input  logic [ECHO_W-1:0] ar_echo,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [ID_W-1:0]   r_id,
    output logic [DATA_W-1:0] r_data,
    output logic [1:0]        r_resp,
    output logic              r_last,
    output logic [ECHO_W-1:0] r_echo
);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA} r_state_e;

    w_state_e        w_state_q, w_state_d;
    r_state_e        r_state_q, r_state_d;
    logic [ID_W-1:0] b_id_q, b_id_d;
    logic [ID_W-1:0] r_id_q, r_id_d;
    logic [7:0]      r_len_q, r_len_d;
    logic [7:0]      r_cnt_q, r_cnt_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            b_id_q    <= '0;
            r_id_q    <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            b_id_q    <= b_id_d;
            r_id_q    <= r_id_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        b_id_d    = b_id_q;
        case (w_state_q)
            W_IDLE: if (aw_valid) begin
                w_state_d = W_DATA;
                b_id_d    = aw_id;
            end
            W_DATA: if (w_valid && w_last) w_state_d = W_RESP;
            W_RESP: if (b_ready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // The counter stops on the last beat, so len 255 never wraps mid-burst.
    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        case (r_state_q)
            R_IDLE: if (ar_valid) begin
                r_state_d = R_DATA;
                r_id_d    = ar_id;
                r_len_d   = ar_len;
                r_cnt_d   = '0;
            end
            R_DATA: if (r_ready) begin
                if (r_cnt_q == r_len_q) r_state_d = R_IDLE;
                else                    r_cnt_d   = r_cnt_q + 8'd1;
            end
        endcase
    end

    assign aw_ready = (w_state_q == W_IDLE);
    assign w_ready  = (w_state_q == W_DATA);
    assign b_valid  = (w_state_q == W_RESP);
    assign b_id     = b_id_q;
    assign b_resp   = ERR_RESP;

    assign ar_ready = (r_state_q == R_IDLE);
    assign r_valid  = (r_state_q == R_DATA);
    assign r_id     = r_id_q;
    assign r_data   = '0;
    assign r_resp   = ERR_RESP;
    assign r_last   = (r_state_q == R_DATA) && (r_cnt_q == r_len_q);

`ifdef AXI4_ERR_RESPONDER_ECHO_EN
    logic [ECHO_W-1:0] b_echo_q, r_echo_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            b_echo_q <= '0;
            r_echo_q <= '0;
        end else begin
            if (aw_valid && aw_ready) b_echo_q <= aw_echo;
            if (ar_valid && ar_ready) r_echo_q <= ar_echo;
        end
    end

    assign b_echo = b_echo_q;
    assign r_echo = r_echo_q;

    logic unused_inputs;
    assign unused_inputs = ^{aw_addr, aw_len, aw_size, aw_burst, w_data, w_strb,
                             ar_addr, ar_size, ar_burst};
`else
    assign b_echo = '0;
    assign r_echo = '0;

    logic unused_inputs;
    assign unused_inputs = ^{aw_addr, aw_len, aw_size, aw_burst, w_data, w_strb,
                             ar_addr, ar_size, ar_burst, aw_echo, ar_echo};
`endif

endmodule

// File: tb/tb_axi4_error_responder.sv
// Directed bench for axi4_error_responder; echo expectations follow
// AXI4_ERR_RESPONDER_ECHO_EN.
module tb_axi4_error_responder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        aw_valid, aw_ready;
    logic [3:0]  aw_id;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic [4:0]  aw_echo;
    logic        w_valid, w_ready;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        w_last;
    logic        b_valid, b_ready;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic [4:0]  b_echo;
    logic        ar_valid, ar_ready;
    logic [3:0]  ar_id;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic [4:0]  ar_echo;
    logic        r_valid, r_ready;
    logic [3:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [4:0]  r_echo;

    int n_checks = 0;
    int n_errors = 0;

    axi4_error_responder dut (
        .clock(clock), .reset_n(reset_n),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
        .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst), .aw_echo(aw_echo),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp), .b_echo(b_echo),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
        .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst), .ar_echo(ar_echo),
        .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
        .r_resp(r_resp), .r_last(r_last), .r_echo(r_echo)
    );

    always #5 clock = ~clock;

    function automatic logic [4:0] exp_echo(input logic [4:0] e);
`ifdef AXI4_ERR_RESPONDER_ECHO_EN
        return e;
`else
        return 5'd0;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        aw_valid = 0; aw_id = 0; aw_addr = 32'h1000; aw_len = 0; aw_size = 3; aw_burst = 1; aw_echo = 0;
        w_valid  = 0; w_data = 64'hDEAD_BEEF_0123_4567; w_strb = 8'hFF; w_last = 0;
        b_ready  = 0;
        ar_valid = 0; ar_id = 0; ar_addr = 32'h2000; ar_len = 0; ar_size = 3; ar_burst = 1; ar_echo = 0;
        r_ready  = 0;
        repeat (3) tick;

        check("rst_aw_ready", aw_ready, 1);
        check("rst_ar_ready", ar_ready, 1);
        check("rst_w_ready",  w_ready, 0);
        check("rst_b_valid",  b_valid, 0);
        check("rst_r_valid",  r_valid, 0);
        check("rst_r_last",   r_last, 0);
        check("rst_b_id",     b_id, 0);
        check("rst_r_id",     r_id, 0);
        check("rst_b_echo",   b_echo, 0);
        check("rst_r_echo",   r_echo, 0);
        check("rst_r_data",   r_data, 0);
        check("rst_b_resp",   b_resp, 2'b11);
        check("rst_r_resp",   r_resp, 2'b11);
        reset_n = 1'b1;
        tick;

        // single write
        b_ready = 1;
        aw_valid = 1; aw_id = 4'd3; aw_echo = 5'h15; aw_len = 0;
        check("wr_aw_ready", aw_ready, 1);
        tick;
        aw_valid = 0;
        check("wr_w_ready", w_ready, 1);
        check("wr_aw_busy", aw_ready, 0);
        w_valid = 1; w_last = 1;
        tick;
        w_valid = 0; w_last = 0;
        check("wr_b_valid", b_valid, 1);
        check("wr_b_id",    b_id, 4'd3);
        check("wr_b_resp",  b_resp, 2'b11);
        check("wr_b_echo",  b_echo, exp_echo(5'h15));
        check("wr_w_done",  w_ready, 0);
        tick;
        check("wr_b_done",  b_valid, 0);
        check("wr_aw_back", aw_ready, 1);

        // read burst of 4
        r_ready = 1;
        ar_valid = 1; ar_id = 4'd9; ar_len = 8'd3; ar_echo = 5'h0A;
        tick;
        ar_valid = 0;
        for (int i = 0; i < 4; i++) begin
            check("rd_valid", r_valid, 1);
            check("rd_id",    r_id, 4'd9);
            check("rd_data",  r_data, 0);
            check("rd_resp",  r_resp, 2'b11);
            check("rd_echo",  r_echo, exp_echo(5'h0A));
            check("rd_last",  r_last, (i == 3));
            check("rd_ar_busy", ar_ready, 0);
            tick;
        end
        check("rd_done", r_valid, 0);
        check("rd_ar_back", ar_ready, 1);

        // write backpressure, two beats
        b_ready = 0;
        aw_valid = 1; aw_id = 4'd5; aw_echo = 5'h07; aw_len = 1;
        tick;
        aw_valid = 0;
        w_valid = 1; w_last = 0;
        tick;
        check("bp_w_mid", w_ready, 1);
        w_last = 1;
        tick;
        w_valid = 0; w_last = 0;
        for (int i = 0; i < 5; i++) begin
            check("bp_b_valid", b_valid, 1);
            check("bp_b_id",    b_id, 4'd5);
            check("bp_b_echo",  b_echo, exp_echo(5'h07));
            check("bp_aw_busy", aw_ready, 0);
            tick;
        end
        b_ready = 1;
        tick;
        b_ready = 0;
        check("bp_b_done", b_valid, 0);

        // read with toggling r_ready
        begin
            int beat = 0;
            r_ready = 0;
            ar_valid = 1; ar_id = 4'd2; ar_len = 8'd2; ar_echo = 5'h1C;
            tick;
            ar_valid = 0;
            for (int cyc = 0; cyc < 20 && beat < 3; cyc++) begin
                r_ready = cyc[0];
                check("bpr_valid", r_valid, 1);
                check("bpr_id",    r_id, 4'd2);
                check("bpr_echo",  r_echo, exp_echo(5'h1C));
                check("bpr_last",  r_last, (beat == 2));
                check("bpr_ar_busy", ar_ready, 0);
                tick;
                if (r_ready) beat++;
            end
            r_ready = 0;
            check("bpr_beats", beat, 3);
            check("bpr_done", r_valid, 0);
            check("bpr_ar_back", ar_ready, 1);
        end

        // maximum length read
        r_ready = 1;
        ar_valid = 1; ar_id = 4'd1; ar_len = 8'd255; ar_echo = 5'h03;
        tick;
        ar_valid = 0;
        for (int i = 0; i < 256; i++) begin
            check("max_valid", r_valid, 1);
            check("max_last",  r_last, (i == 255));
            tick;
        end
        check("max_done", r_valid, 0);
        check("max_ar_back", ar_ready, 1);

        // early W while a read is active
        r_ready = 0; b_ready = 0;
        w_valid = 1; w_last = 1;
        ar_valid = 1; ar_id = 4'd6; ar_len = 8'd1; ar_echo = 5'h11;
        check("ew_stall0", w_ready, 0);
        tick;
        ar_valid = 0;
        check("ew_stall1", w_ready, 0);
        check("ew_r_valid", r_valid, 1);
        tick;
        check("ew_stall2", w_ready, 0);
        aw_valid = 1; aw_id = 4'hA; aw_echo = 5'h12;
        tick;
        aw_valid = 0;
        check("ew_w_ready", w_ready, 1);
        check("ew_r_hold", r_last, 0);
        check("ew_r_id", r_id, 4'd6);
        tick;
        w_valid = 0; w_last = 0;
        check("ew_b_valid", b_valid, 1);
        check("ew_b_id", b_id, 4'hA);
        check("ew_b_echo", b_echo, exp_echo(5'h12));
        r_ready = 1;
        tick;
        check("ew_r_last", r_last, 1);
        check("ew_r_echo", r_echo, exp_echo(5'h11));
        tick;
        r_ready = 0;
        check("ew_r_done", r_valid, 0);
        check("ew_b_still", b_valid, 1);
        b_ready = 1;
        tick;
        check("ew_b_done", b_valid, 0);
        check("ew_aw_back", aw_ready, 1);

        // simultaneous AW and AR
        aw_valid = 1; aw_id = 4'hC; aw_echo = 5'h01;
        ar_valid = 1; ar_id = 4'hD; ar_len = 8'd0; ar_echo = 5'h02;
        tick;
        aw_valid = 0; ar_valid = 0;
        check("sim_w_ready", w_ready, 1);
        check("sim_r_valid", r_valid, 1);
        check("sim_r_id", r_id, 4'hD);
        w_valid = 1; w_last = 1; r_ready = 1;
        tick;
        w_valid = 0; w_last = 0;
        check("sim_b_id", b_id, 4'hC);
        check("sim_r_done", r_valid, 0);
        tick;
        check("sim_b_done", b_valid, 0);

        // reset during beat 2 of a read
        r_ready = 1;
        ar_valid = 1; ar_id = 4'd4; ar_len = 8'd3; ar_echo = 5'h1F;
        tick;
        ar_valid = 0;
        tick;
        check("rr_beat2", r_valid, 1);
        reset_n = 0;
        #1;
        check("rr_r_valid", r_valid, 0);
        check("rr_ar_ready", ar_ready, 1);
        tick;
        reset_n = 1;
        check("rr_rel_r_valid", r_valid, 0);
        check("rr_rel_ar_ready", ar_ready, 1);
        check("rr_rel_b_valid", b_valid, 0);
        tick;
        ar_valid = 1; ar_id = 4'd7; ar_len = 8'd0; ar_echo = 5'h09;
        tick;
        ar_valid = 0;
        check("rr_new_valid", r_valid, 1);
        check("rr_new_id", r_id, 4'd7);
        check("rr_new_last", r_last, 1);
        check("rr_new_echo", r_echo, exp_echo(5'h09));
        tick;
        check("rr_new_done", r_valid, 0);
        check("rr_new_ar", ar_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
